// File: rtl/io_timer.sv
// Memory-mapped down-counting timer with prescaler, periodic/one-shot modes,
// sticky pending flag, overrun flag and a level interrupt (PEND & IE).
module io_timer #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  io_addr,
    input  logic        io_write,
    input  logic        io_read,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    output logic        interrupt
);

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_PRESCALE = 4'd1;
    localparam logic [3:0] ADDR_RELOAD   = 4'd2;
    localparam logic [3:0] ADDR_COUNT    = 4'd3;
    localparam logic [3:0] ADDR_STATUS   = 4'd4;

    logic             en_q, en_d;
    logic             periodic_q, periodic_d;
    logic             ie_q, ie_d;
    logic             pend_q, pend_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] prescale_q, prescale_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] psc_q, psc_d;

    logic             wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
    logic             ctrl_disable, tick, expire, pend_clr, ovr_clr;
    logic [WIDTH-1:0] wdata_w;

    // Reads are side-effect free, so the read strobe carries no information.
    logic [16:0] unused_bits;
    assign unused_bits = {io_read, io_wdata};

    assign wdata_w     = io_wdata[WIDTH-1:0];
    assign wr_ctrl     = io_write && (io_addr == ADDR_CTRL);
    assign wr_prescale = io_write && (io_addr == ADDR_PRESCALE);
    assign wr_reload   = io_write && (io_addr == ADDR_RELOAD);
    assign wr_count    = io_write && (io_addr == ADDR_COUNT);
    assign wr_status   = io_write && (io_addr == ADDR_STATUS);

    assign ctrl_disable = wr_ctrl && !io_wdata[0];
    assign pend_clr     = wr_status && io_wdata[0];
    assign ovr_clr      = wr_status && io_wdata[1];
    assign tick         = en_q && (psc_q == prescale_q);

    function automatic logic [15:0] zext(input logic [WIDTH-1:0] v);
        zext           = '0;
        zext[WIDTH-1:0] = v;
    endfunction

    always_comb begin
        en_d       = en_q;
        periodic_d = periodic_q;
        ie_d       = ie_q;
        pend_d     = pend_q;
        ovr_d      = ovr_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        count_d    = count_q;
        psc_d      = en_q ? (tick ? '0 : psc_q + WIDTH'(1)) : '0;
        expire     = 1'b0;

        // A COUNT write or an EN-clearing CTRL write pre-empts the tick.
        if (tick && !wr_count && !ctrl_disable) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else begin
                expire = 1'b1;
                if (periodic_q) begin
                    count_d = reload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (pend_clr) pend_d = 1'b0;
        if (ovr_clr)  ovr_d  = 1'b0;
        if (expire) begin
            pend_d = 1'b1;
            if (pend_q && !pend_clr) ovr_d = 1'b1;
        end

        if (wr_prescale) begin
            prescale_d = wdata_w;
            psc_d      = '0;
        end
        if (wr_reload) reload_d = wdata_w;

        if (wr_ctrl) begin
            periodic_d = io_wdata[1];
            ie_d       = io_wdata[2];
            if (!io_wdata[0]) begin
                en_d  = 1'b0;
                psc_d = '0;
            end else if (!en_q) begin
                en_d    = 1'b1;
                count_d = reload_q;
                psc_d   = '0;
            end
        end

        if (wr_count) count_d = wdata_w;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q       <= 1'b0;
            periodic_q <= 1'b0;
            ie_q       <= 1'b0;
            pend_q     <= 1'b0;
            ovr_q      <= 1'b0;
            prescale_q <= '0;
            reload_q   <= '0;
            count_q    <= '0;
            psc_q      <= '0;
        end else begin
            en_q       <= en_d;
            periodic_q <= periodic_d;
            ie_q       <= ie_d;
            pend_q     <= pend_d;
            ovr_q      <= ovr_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            psc_q      <= psc_d;
        end
    end

    always_comb begin
        io_rdata = '0;
        case (io_addr)
            ADDR_CTRL:     io_rdata = {13'd0, ie_q, periodic_q, en_q};
            ADDR_PRESCALE: io_rdata = zext(prescale_q);
            ADDR_RELOAD:   io_rdata = zext(reload_q);
            ADDR_COUNT:    io_rdata = zext(count_q);
            ADDR_STATUS:   io_rdata = {14'd0, ovr_q, pend_q};
            default:       io_rdata = '0;
        endcase
    end

    assign interrupt = pend_q && ie_q;

endmodule

// File: doc/io_timer.md
Name: io_timer

Overview:
- Memory-mapped 16-bit down-counting timer on the CPU I/O bus, in the same decoded I/O window as uart, spi and gpio.
- Produces a level interrupt that feeds the interrupt controller (intr), either as a new source or alongside the existing ones.
- Provides a programmable prescaler, periodic or one-shot operation, a sticky pending flag and an overrun flag.
- Used for the OS tick and for software delays.

Parameters:
- WIDTH, 16: width of the counter, reload and prescaler registers; must be ≤16 (the data bus width).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous reset, active-low (0 = reset).
- io_addr  in  4  register select; the top level drives it from addr[4:1] (16-bit word index).
- io_write  in  1  write strobe; one cycle per access; already qualified by window decode and !fault.
- io_read  in  1  read strobe; informational only; reads have no side effects.
- io_wdata  in  16  write data.
- io_rdata  out  16  read data; combinational from io_addr.
- interrupt  out  1  level interrupt = PEND & IE.

Behaviour:
- Register map (io_addr):
  - 0 CTRL: [0] EN, [1] PERIODIC, [2] IE; other bits read 0.
  - 1 PRESCALE.
  - 2 RELOAD.
  - 3 COUNT: read returns the current count; write loads the count.
  - 4 STATUS: [0] PEND, [1] OVR; writing 1 to a bit clears it (W1C).
  - 5-15: read 0, writes ignored.
- Reset (async, reset=0): all registers and the prescaler counter psc clear to 0, so interrupt=0.
  - Release takes effect on the first clk edge with reset=1.
- Prescaler:
  - While EN=1, psc increments each clk.
  - When psc==PRESCALE, psc returns to 0 and a one-cycle internal tick fires.
  - Tick period is PRESCALE+1 clks; PRESCALE=0 means a tick every clk.
  - While EN=0, psc holds at 0.
- Counter, on each tick:
  - If COUNT≠0: COUNT decrements by 1.
  - If COUNT==0 (expiry): PEND←1. OVR←1 if PEND was already 1 and is not being cleared in the same cycle.
  - On expiry with PERIODIC=1: COUNT←RELOAD.
  - On expiry with PERIODIC=0: EN←0 and COUNT stays 0.
- Expiry period: (RELOAD+1)×(PRESCALE+1) clks.
- CTRL write with EN changing 0→1: COUNT←RELOAD and psc←0 on that same edge. The first tick follows PRESCALE+1 clks later.
- CTRL write with EN already 1 (EN 1→1): only PERIODIC and IE update; psc and COUNT are unaffected.
- EN 1→0 by write: counting freezes and psc←0. COUNT holds its value.
- PRESCALE write: psc←0.
- RELOAD write: takes effect at the next reload only; it does not alter the current COUNT.
- Simultaneous events:
  - COUNT write coinciding with a tick or expiry: the write wins, with no decrement and no PEND set.
  - W1C of PEND in the same cycle as an expiry: PEND stays 1 (set wins); OVR is not set.
  - CTRL write clearing EN coinciding with a tick: the write wins, with no expiry.
- Wrap-around: COUNT never underflows; 0 is the expiry state.
  - RELOAD=0 with PERIODIC=1 expires on every tick.
- interrupt is combinational from the PEND and IE flops. It rises the cycle after the expiry edge and stays high until PEND is cleared or IE=0.
- Latencies:
  - Writes take effect at the clk edge on which io_write is sampled.
  - Reads are zero-latency.

Test Plan:
- Reset values:
  - Hold reset=0 mid-count (EN=1, COUNT=7) → all reads 0 and interrupt=0 immediately, without waiting for clk.
  - Release reset → the timer stays idle.
- Periodic timing:
  - PRESCALE=3, RELOAD=4, then CTRL=0x7.
  - First PEND/interrupt at exactly the 20th clk edge after the CTRL write edge; COUNT reads 4,3,2,1,0 changing every 4 clks.
  - Second expiry 20 clks later sets OVR=1.
  - Write STATUS=0x3 → both flags clear and interrupt falls.
- One-shot:
  - PRESCALE=0, RELOAD=2, CTRL=0x5.
  - PEND at the 3rd edge, then CTRL reads 0x4 (EN cleared) and COUNT reads 0.
  - No further expiry after 100 clks.
- Collisions:
  - W1C of PEND on the expiry edge (RELOAD=0, PRESCALE=0) → PEND remains 1 and OVR stays 0.
  - COUNT write of 9 on a tick edge → COUNT reads 9, not 8.
- IE masking:
  - Run with IE=0 until PEND=1 → interrupt stays 0.
  - Set IE=1 → interrupt is 1 the following cycle.
- Unmapped addresses:
  - Read io_addr 5..15 → 0.
  - Writes of 0xFFFF to them → no register changes.
